icache_refill_axi: RTL and testbench

- AXI4 read-burst master that refills one I-cache line per miss.
- Accepts a miss address from the ICache and issues a single INCR burst on the shared AXI read channels, which connect to the memory model / interconnect.
- Collects the returned beats into a line buffer and hands the complete line back to the ICache with a valid/ready handshake.
- Supports a frontend flush that cancels the refill without violating AXI protocol.

---
 rtl/icache_refill_axi_if.sv | 26 ++
 rtl/icache_refill_axi.sv | 141 ++++++++++++++
 tb/tb_icache_refill_axi.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_refill_axi_if.sv
// rtl/icache_refill_axi_if.sv - AXI4 read address/data channel bundle for the I-cache refill engine
interface icache_refill_axi_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/icache_refill_axi.sv
// rtl/icache_refill_axi.sv - single-burst AXI4 line refill engine with flush-safe drain
module icache_refill_axi #(
    parameter int         LINE_WORDS = 8,
    parameter logic [3:0] AXI_ID     = 4'h0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [31:0]               req_addr,
    input  logic                      flush,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [31:0]               resp_addr,
    output logic [32*LINE_WORDS-1:0]  resp_line,
    output logic                      resp_err,
    icache_refill_axi_if.master       m_axi
);
    localparam int             CW       = $clog2(LINE_WORDS);
    localparam logic [CW-1:0]  LAST     = CW'(LINE_WORDS - 1);
    localparam logic [31:0]    OFS_MASK = 32'(LINE_WORDS * 4 - 1);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_DONE, S_DRAIN} state_t;

    state_t        state;
    logic          idle_q;
    logic          arvalid_q;
    logic          rready_q;
    logic          flush_pend;
    logic          err;
    logic [31:0]   araddr_q;
    logic [CW-1:0] cnt;

    logic beat;
    logic final_beat;
    logic beat_err;
    logic err_next;

    assign beat       = m_axi.rvalid && rready_q;
    assign final_beat = beat && (cnt == LAST);
    // The burst always ends by count; rlast only flags a length disagreement.
    assign beat_err   = (m_axi.rresp >= 2'b10) || (m_axi.rlast != (cnt == LAST));
    assign err_next   = err || (beat && beat_err);

    assign req_ready      = idle_q && !flush;
    assign m_axi.arid     = AXI_ID;
    assign m_axi.araddr   = araddr_q;
    assign m_axi.arlen    = 8'(LINE_WORDS - 1);
    assign m_axi.arsize   = 3'b010;
    assign m_axi.arburst  = 2'b01;
    assign m_axi.arvalid  = arvalid_q;
    assign m_axi.rready   = rready_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            idle_q     <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            flush_pend <= 1'b0;
            err        <= 1'b0;
            araddr_q   <= '0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_addr  <= '0;
            resp_line  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        state     <= S_AR;
                        idle_q    <= 1'b0;
                        arvalid_q <= 1'b1;
                        araddr_q  <= req_addr & ~OFS_MASK;
                        cnt       <= '0;
                    end else begin
                        idle_q <= 1'b1;
                    end
                end
                S_AR: begin
                    // arvalid cannot be withdrawn, so a flush here is remembered.
                    if (flush) flush_pend <= 1'b1;
                    if (m_axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        cnt       <= '0;
                        state     <= (flush_pend || flush) ? S_DRAIN : S_R;
                    end
                end
                S_R: begin
                    if (beat) begin
                        resp_line[32*int'(cnt) +: 32] <= m_axi.rdata;
                        cnt <= cnt + CW'(1);
                        err <= err_next;
                    end
                    if (final_beat) begin
                        rready_q <= 1'b0;
                        if (flush) begin
                            state      <= S_IDLE;
                            idle_q     <= 1'b1;
                            err        <= 1'b0;
                            flush_pend <= 1'b0;
                        end else begin
                            state      <= S_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= err_next;
                            resp_addr  <= araddr_q;
                        end
                    end else if (flush) begin
                        state <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    if (resp_ready || flush) begin
                        resp_valid <= 1'b0;
                        state      <= S_IDLE;
                        idle_q     <= 1'b1;
                        err        <= 1'b0;
                        flush_pend <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (beat) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            rready_q   <= 1'b0;
                            state      <= S_IDLE;
                            idle_q     <= 1'b1;
                            err        <= 1'b0;
                            flush_pend <= 1'b0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) beat |-> (m_axi.rid == AXI_ID));
endmodule

// File: tb/tb_icache_refill_axi.sv
// tb/tb_icache_refill_axi.sv - randomized bench with AXI slave model and line-level reference
module tb_icache_refill_axi;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_addr = '0;
    logic          flush = 1'b0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [31:0]   resp_addr;
    logic [32*LW-1:0] resp_line;
    logic          resp_err;

    icache_refill_axi_if m_axi();

    icache_refill_axi #(.LINE_WORDS(LW), .AXI_ID(4'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_addr(resp_addr),
        .resp_line(resp_line), .resp_err(resp_err),
        .m_axi(m_axi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Slave configuration and memory content: word i of the burst is seed + i*mul.
    int          cfg_ar_delay = 0;
    int          cfg_gap = 0;
    int          cfg_err_beat = -1;
    int          cfg_last_beat = LW - 1;
    logic [31:0] cfg_seed = 0;
    logic [31:0] cfg_mul = 1;

    int          s_beat = 0;
    int          s_wait = 0;
    int          ar_cnt = 0;
    bit          s_active = 0;
    bit          ar_fire, r_fire;
    logic [31:0] ar_addr_smp;
    logic [7:0]  ar_len_smp;
    logic [2:0]  ar_size_smp;
    logic [1:0]  ar_burst_smp;
    logic [3:0]  ar_id_smp;

    function automatic logic [255:0] exp_line();
        logic [255:0] l;
        l = '0;
        for (int i = 0; i < LW; i++) l[32*i +: 32] = cfg_seed + 32'(i) * cfg_mul;
        return l;
    endfunction

    function automatic bit exp_err();
        return (cfg_err_beat >= 0 && cfg_err_beat < LW) || (cfg_last_beat != LW - 1);
    endfunction

    initial begin
        m_axi.arready = 1'b0;
        m_axi.rvalid  = 1'b0;
        m_axi.rdata   = '0;
        m_axi.rresp   = 2'b00;
        m_axi.rlast   = 1'b0;
        m_axi.rid     = 4'h0;
        forever begin
            @(negedge clk);
            ar_fire = m_axi.arvalid && m_axi.arready;
            r_fire  = m_axi.rvalid && m_axi.rready;
            if (ar_fire) begin
                ar_addr_smp  = m_axi.araddr;
                ar_len_smp   = m_axi.arlen;
                ar_size_smp  = m_axi.arsize;
                ar_burst_smp = m_axi.arburst;
                ar_id_smp    = m_axi.arid;
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                m_axi.arready = 1'b0;
                m_axi.rvalid  = 1'b0;
                m_axi.rlast   = 1'b0;
                s_active = 0;
                s_beat   = 0;
                s_wait   = cfg_ar_delay;
            end else begin
                if (ar_fire) begin
                    ar_cnt++;
                    s_active = 1;
                    s_beat   = 0;
                end
                if (r_fire) begin
                    s_beat++;
                    if (s_beat == LW) s_active = 0;
                end
                m_axi.arready = 1'b0;
                if (!m_axi.arvalid) s_wait = cfg_ar_delay;
                else if (s_wait > 0) s_wait--;
                else m_axi.arready = 1'b1;
                if (r_fire || !m_axi.rvalid) begin
                    if (s_active && $urandom_range(99) >= cfg_gap) begin
                        m_axi.rvalid = 1'b1;
                        m_axi.rdata  = cfg_seed + 32'(s_beat) * cfg_mul;
                        m_axi.rresp  = (s_beat == cfg_err_beat) ? 2'b10 : 2'b00;
                        m_axi.rlast  = (s_beat == cfg_last_beat);
                    end else begin
                        m_axi.rvalid = 1'b0;
                        m_axi.rlast  = 1'b0;
                    end
                end
            end
        end
    end

    // Handshake-stability watchers; all drives change only just after posedge.
    int   ar_unstable = 0;
    int   line_unstable = 0;
    int   resp_seen = 0;
    logic p_rst = 0, p_arvalid = 0, p_arready = 0, p_rv = 0, p_rr = 0, p_err = 0, p_flush = 0;
    logic [31:0] p_araddr = 0, p_addr = 0;
    logic [255:0] p_line = 0;

    always @(negedge clk) begin
        if (resp_valid) resp_seen++;
        if (p_rst) begin
            if (p_arvalid && !p_arready && (!m_axi.arvalid || m_axi.araddr !== p_araddr))
                ar_unstable++;
            if (p_rv && !p_rr && !p_flush &&
                (!resp_valid || resp_line !== p_line || resp_addr !== p_addr || resp_err !== p_err))
                line_unstable++;
        end
        p_rst = rst_n; p_arvalid = m_axi.arvalid; p_arready = m_axi.arready;
        p_araddr = m_axi.araddr; p_rv = resp_valid; p_rr = resp_ready; p_flush = flush;
        p_line = resp_line; p_addr = resp_addr; p_err = resp_err;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_cfg(input int d, input int g, input int eb, input int lb);
        cfg_ar_delay = d; cfg_gap = g; cfg_err_beat = eb; cfg_last_beat = lb;
        cfg_seed = $urandom; cfg_mul = $urandom;
    endtask

    task automatic request(input logic [31:0] a);
        bit ok;
        ok = 0;
        step();
        req_addr = a;
        req_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        step();
        req_valid = 1'b0;
        req_addr = $urandom;
        check("req_accept", ok, 1);
    endtask

    task automatic expect_resp(input int hold, input logic [31:0] a, input int exp_lat);
        int n;
        bit seen;
        seen = 0;
        for (n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (resp_valid) begin seen = 1; break; end
        end
        check("resp_seen", seen, 1);
        if (exp_lat > 0) check("latency", n, exp_lat);
        check("resp_addr", resp_addr, a & ~32'(LW*4 - 1));
        check("resp_line", resp_line, exp_line());
        check("resp_err", resp_err, exp_err());
        repeat (hold) step();
        @(negedge clk);
        check("resp_held", resp_valid, 1);
        step();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        @(negedge clk);
        check("resp_dropped", resp_valid, 0);
        check("req_ready_idle", req_ready, 1);
    endtask

    task automatic drain_wait(input string tag);
        int low;
        bit done;
        low = 0;
        done = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (s_active && !m_axi.rready) low++;
            if (m_axi.rvalid && m_axi.rready && s_beat == LW - 1) begin done = 1; break; end
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_rready_held"}, low, 0);
        @(negedge clk);
        check({tag, "_req_ready"}, req_ready, 1);
        check({tag, "_beats"}, s_beat, LW);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_arvalid"}, m_axi.arvalid, 0);
        check({tag, "_rready"}, m_axi.rready, 0);
        check({tag, "_resp_valid"}, resp_valid, 0);
        check({tag, "_resp_err"}, resp_err, 0);
        check({tag, "_resp_addr"}, resp_addr, 0);
        check({tag, "_resp_line"}, resp_line, 0);
        check({tag, "_araddr"}, m_axi.araddr, 0);
    endtask

    task automatic wait_beat(input int b);
        bit hit;
        hit = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (s_active && m_axi.rvalid && s_beat == b) begin hit = 1; break; end
        end
        check("wait_beat", hit, 1);
    endtask

    initial begin
        int base, seen0;
        logic [31:0] a;

        repeat (3) step();
        @(negedge clk);
        check_zero("rst");
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        check("req_ready_after_rst", req_ready, 1);

        // Basic refill with memory words 0..7
        set_cfg(0, 0, -1, LW - 1);
        cfg_seed = 0; cfg_mul = 1;
        base = ar_cnt;
        request(32'h0000_0114);
        expect_resp(0, 32'h0000_0114, LW + 2);
        check("ar_addr", ar_addr_smp, 32'h100);
        check("ar_len", ar_len_smp, 7);
        check("ar_size", ar_size_smp, 2);
        check("ar_burst", ar_burst_smp, 1);
        check("ar_id", ar_id_smp, 0);
        check("ar_count_basic", ar_cnt - base, 1);

        // Backpressure on every channel
        set_cfg(3, 40, -1, LW - 1);
        base = ar_cnt;
        a = $urandom;
        request(a);
        expect_resp(4, a, -1);
        check("ar_count_bp", ar_cnt - base, 1);

        for (int t = 0; t < 12; t++) begin
            int eb, lb;
            eb = ($urandom_range(3) == 0) ? int'($urandom_range(LW - 1)) : -1;
            lb = ($urandom_range(4) == 0) ? (($urandom_range(1) == 0) ? int'($urandom_range(LW - 2)) : 99) : LW - 1;
            set_cfg(int'($urandom_range(3)), int'($urandom_range(50)), eb, lb);
            base = ar_cnt;
            a = $urandom;
            request(a);
            expect_resp(int'($urandom_range(4)), a, -1);
            check("ar_count_rand", ar_cnt - base, 1);
        end

        // Flush in R after three beats
        set_cfg(0, 0, -1, LW - 1);
        base = ar_cnt;
        seen0 = resp_seen;
        request(32'h0000_0340);
        wait_beat(2);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        drain_wait("flush_r");
        check("flush_r_no_resp", resp_seen - seen0, 0);
        check("flush_r_ar_count", ar_cnt - base, 1);
        set_cfg(0, 20, -1, LW - 1);
        request(32'h0000_0200);
        expect_resp(1, 32'h0000_0200, -1);

        // Flush while arvalid waits for arready
        set_cfg(3, 0, -1, LW - 1);
        base = ar_cnt;
        seen0 = resp_seen;
        request(32'h0000_1234);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drain_wait("flush_ar");
        check("flush_ar_no_resp", resp_seen - seen0, 0);
        check("flush_ar_ar_count", ar_cnt - base, 1);

        // Flush while the line is being offered
        set_cfg(0, 0, -1, LW - 1);
        request(32'h0000_5560);
        wait_beat(LW - 1);
        @(negedge clk);
        check("done_valid", resp_valid, 1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        check("flush_done_valid", resp_valid, 0);
        check("flush_done_req_ready", req_ready, 1);

        // Error responses
        set_cfg(0, 30, 4, LW - 1);
        a = $urandom;
        request(a);
        expect_resp(1, a, -1);
        set_cfg(0, 30, -1, 5);
        a = $urandom;
        request(a);
        expect_resp(0, a, -1);
        check("early_rlast_beats", s_beat, LW);
        set_cfg(0, 0, -1, 99);
        a = $urandom;
        request(a);
        expect_resp(0, a, -1);

        // Reset in the middle of a burst
        set_cfg(0, 0, -1, LW - 1);
        request(32'h0000_7700);
        wait_beat(2);
        step();
        rst_n = 1'b0;
        step();
        @(negedge clk);
        check_zero("mid_rst");
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        check("mid_rst_req_ready", req_ready, 1);
        set_cfg(1, 25, -1, LW - 1);
        a = $urandom;
        request(a);
        expect_resp(2, a, -1);

        check("ar_stable", ar_unstable, 0);
        check("line_stable", line_unstable, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
